// File: rtl/biu_constants_pkg.sv
// Bus-interface constants shared by BIU clients: access-size encoding.
package biu_constants_pkg;

  typedef logic [2:0] biu_size_t;

  localparam biu_size_t BIU_BYTE  = 3'd0;
  localparam biu_size_t BIU_HWORD = 3'd1;
  localparam biu_size_t BIU_WORD  = 3'd2;
  localparam biu_size_t BIU_DWORD = 3'd3;

endpackage

// File: rtl/riscv_dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: owner FSM encoding and requester indices.
package riscv_dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int unsigned REQ_LSU = 0;
  localparam int unsigned REQ_AUX = 1;
  localparam int unsigned NUM_REQ = 2;

  function automatic arb_state_t owner_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/riscv_dmem_arb.sv
// Two-requester data-memory arbiter (LSU vs. PTW/debug) with outstanding-request and burst limits.
// Define RISCV_DMEM_ARB_RR_EN for round-robin owner selection; otherwise the LSU wins ties.
module riscv_dmem_arb
  import riscv_dmem_arb_pkg::*;
  import biu_constants_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MAX_BURST       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           rq_req,
  input  logic [1:0]           rq_we,
  input  logic [1:0][XLEN-1:0] rq_adr,
  input  logic [1:0][XLEN-1:0] rq_d,
  input  biu_size_t [1:0]      rq_size,
  output logic [1:0]           rq_gnt,
  output logic [1:0]           rq_ack,
  output logic [XLEN-1:0]      rq_q,
  output logic                 rq_misaligned,
  output logic                 rq_page_fault,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_adr,
  output logic [XLEN-1:0]      mem_d,
  output biu_size_t            mem_size,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_q,
  input  logic                 mem_misaligned,
  input  logic                 mem_page_fault
);

  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [XLEN-1:0]    mem_adr_q, mem_adr_d;
  logic [XLEN-1:0]    mem_d_q, mem_d_d;
  biu_size_t          mem_size_q, mem_size_d;
`ifdef RISCV_DMEM_ARB_RR_EN
  logic               last_q, last_d;
`endif

  logic       owner;
  logic       has_owner;
  logic       ack_ok;
  logic       room;
  logic       drained;
  logic       burst_hit;
  logic       issue;
  logic       sel;
  logic [1:0] cand;
  logic [1:0] gnt_c;
  logic [1:0] ack_c;

  // Owner FSM, grant selection and counters
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    gnt_c     = 2'b00;
    ack_c     = 2'b00;
    sel       = 1'b0;
    cand      = rq_req;
`ifdef RISCV_DMEM_ARB_RR_EN
    last_d    = last_q;
`endif
    owner     = (state_q == OWN1);
    has_owner = (state_q != IDLE);
    ack_ok    = mem_ack && (cnt_q != '0);
    room      = (cnt_q < CNT_W'(MAX_OUTSTANDING)) || ack_ok;
    drained   = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && ack_ok);
    burst_hit = (burst_q >= BURST_W'(MAX_BURST)) && rq_req[~owner];

    if (has_owner && rq_req[owner] && !burst_hit) begin
      if (room) begin
        gnt_c[owner] = 1'b1;
        sel          = owner;
        if (burst_q < BURST_W'(MAX_BURST)) burst_d = burst_q + BURST_W'(1);
      end
    end else if (drained) begin
      // A burst-limited owner is excluded so the waiting requester takes over.
      if (has_owner && rq_req[owner]) cand[owner] = 1'b0;
      if (cand == 2'b00) begin
        state_d = IDLE;
        burst_d = '0;
      end else begin
`ifdef RISCV_DMEM_ARB_RR_EN
        sel = (cand == 2'b11) ? ~last_q : cand[1];
`else
        sel = ~cand[0];
`endif
        gnt_c[sel] = 1'b1;
        state_d    = owner_state(sel);
        burst_d    = BURST_W'(1);
      end
    end

    issue = |gnt_c;
    cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(ack_ok);
`ifdef RISCV_DMEM_ARB_RR_EN
    if (issue) last_d = sel;
`endif

    // Completions follow the registered owner, so a final ack in a switch cycle stays with it.
    if (ack_ok && has_owner) ack_c[owner] = 1'b1;

    mem_req_d  = issue;
    mem_we_d   = issue ? rq_we[sel]   : mem_we_q;
    mem_adr_d  = issue ? rq_adr[sel]  : mem_adr_q;
    mem_d_d    = issue ? rq_d[sel]    : mem_d_q;
    mem_size_d = issue ? rq_size[sel] : mem_size_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      burst_q   <= '0;
      mem_req_q <= 1'b0;
`ifdef RISCV_DMEM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      mem_req_q <= mem_req_d;
`ifdef RISCV_DMEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  // Command payload needs no reset; it is qualified by mem_req.
  always_ff @(posedge clk) begin
    mem_we_q   <= mem_we_d;
    mem_adr_q  <= mem_adr_d;
    mem_d_q    <= mem_d_d;
    mem_size_q <= mem_size_d;
  end

  assign rq_gnt        = rst ? 2'b00 : gnt_c;
  assign rq_ack        = rst ? 2'b00 : ack_c;
  assign rq_q          = mem_q;
  assign rq_misaligned = mem_misaligned;
  assign rq_page_fault = mem_page_fault;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_adr       = mem_adr_q;
  assign mem_d         = mem_d_q;
  assign mem_size      = mem_size_q;

  a_no_stray_ack: assert property (@(posedge clk) disable iff (rst) !(mem_ack && (cnt_q == '0)));
  a_ack_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(rq_ack));

endmodule

// File: tb/tb_riscv_dmem_arb.sv
// Self-checking bench for riscv_dmem_arb: directed scenarios plus random traffic against a queue model.
module tb_riscv_dmem_arb;
  import biu_constants_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned MO   = 2;
  localparam int unsigned MB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]           rq_req = '0;
  logic [1:0]           rq_we  = '0;
  logic [1:0][XLEN-1:0] rq_adr = '0;
  logic [1:0][XLEN-1:0] rq_d   = '0;
  biu_size_t [1:0]      rq_size = '0;
  logic [1:0]           rq_gnt, rq_ack;
  logic [XLEN-1:0]      rq_q;
  logic                 rq_misaligned, rq_page_fault;
  logic                 mem_req, mem_we;
  logic [XLEN-1:0]      mem_adr, mem_d;
  biu_size_t            mem_size;
  logic                 mem_ack = 1'b0;
  logic [XLEN-1:0]      mem_q = '0;
  logic                 mem_misaligned = 1'b0;
  logic                 mem_page_fault = 1'b0;

  riscv_dmem_arb #(.XLEN(XLEN), .MAX_OUTSTANDING(MO), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .rq_req(rq_req), .rq_we(rq_we), .rq_adr(rq_adr), .rq_d(rq_d), .rq_size(rq_size),
    .rq_gnt(rq_gnt), .rq_ack(rq_ack), .rq_q(rq_q),
    .rq_misaligned(rq_misaligned), .rq_page_fault(rq_page_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_d(mem_d), .mem_size(mem_size),
    .mem_ack(mem_ack), .mem_q(mem_q),
    .mem_misaligned(mem_misaligned), .mem_page_fault(mem_page_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: owner (-1 = none), grants in the current streak, and the in-flight queue of owners
  int              owner;
  int              streak;
  int              last_srv;
  int              inflight[$];
  logic            exp_mreq;
  logic            exp_mwe;
  logic [XLEN-1:0] exp_madr, exp_md;
  biu_size_t       exp_msize;
  logic [1:0]      obs_gnt, obs_ack;
  logic [XLEN-1:0] obs_q;

  task automatic model_reset();
    owner    = -1;
    streak   = 0;
    last_srv = 1;
    inflight.delete();
    exp_mreq = 1'b0;
  endtask

  task automatic model_decide(output logic [1:0] g, output bit idle);
    int         cnt;
    bit         ack, room, drained;
    logic [1:0] cand;
    cnt     = inflight.size();
    ack     = mem_ack && (cnt > 0);
    room    = (cnt < int'(MO)) || ack;
    drained = (cnt == 0) || (cnt == 1 && ack);
    g       = 2'b00;
    idle    = 1'b0;
    if (owner >= 0 && rq_req[owner] && !(streak >= int'(MB) && rq_req[1-owner])) begin
      if (room) g[owner] = 1'b1;
    end else if (drained) begin
      cand = rq_req;
      if (owner >= 0 && rq_req[owner]) cand[owner] = 1'b0;
      if (cand == 2'b00) idle = 1'b1;
      else if (cand == 2'b11) begin
`ifdef RISCV_DMEM_ARB_RR_EN
        g[1-last_srv] = 1'b1;
`else
        g[0] = 1'b1;
`endif
      end else g = cand;
    end
  endtask

  // One clock: inputs are already driven; check mid-cycle, then advance the model across the edge.
  task automatic run_cycle();
    logic [1:0] m_gnt, exp_ack;
    bit         m_idle, ack_taken;
    int         g;
    logic       c_we;
    logic [XLEN-1:0] c_adr, c_d;
    biu_size_t  c_sz;
    #4;
    model_decide(m_gnt, m_idle);
    ack_taken = mem_ack && (inflight.size() > 0);
    exp_ack   = ack_taken ? ((inflight[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
    obs_gnt   = rq_gnt;
    obs_ack   = rq_ack;
    obs_q     = rq_q;
    check_eq("rq_gnt", rq_gnt, m_gnt);
    check_eq("rq_ack", rq_ack, exp_ack);
    if (exp_ack != 2'b00) begin
      check_eq("rq_q", rq_q, mem_q);
      check_eq("rq_err", {rq_misaligned, rq_page_fault}, {mem_misaligned, mem_page_fault});
    end
    check_eq("mem_req", mem_req, exp_mreq);
    if (exp_mreq) begin
      check_eq("mem_adr", mem_adr, exp_madr);
      check_eq("mem_wd", {mem_we, mem_size, mem_d}, {exp_mwe, exp_msize, exp_md});
    end
    g     = m_gnt[1] ? 1 : 0;
    c_we  = rq_we[g];
    c_adr = rq_adr[g];
    c_d   = rq_d[g];
    c_sz  = rq_size[g];
    @(posedge clk);
    #1;
    if (ack_taken) void'(inflight.pop_front());
    exp_mreq = |m_gnt;
    if (|m_gnt) begin
      inflight.push_back(g);
      streak    = (g != owner) ? 1 : streak + 1;
      owner     = g;
      last_srv  = g;
      exp_mwe   = c_we;
      exp_madr  = c_adr;
      exp_md    = c_d;
      exp_msize = c_sz;
    end else if (m_idle) begin
      owner  = -1;
      streak = 0;
    end
  endtask

  // Reset with both requesters asserting and stray acks arriving; nothing may leak out.
  task automatic do_reset();
    rst     = 1'b1;
    rq_req  = 2'b11;
    mem_ack = 1'b1;
    mem_q   = $urandom;
    for (int i = 0; i < 3; i++) begin
      #4;
      check_eq("rst_gnt", rq_gnt, 2'b00);
      check_eq("rst_ack", rq_ack, 2'b00);
      if (i > 0) check_eq("rst_mem_req", mem_req, 1'b0);
      @(posedge clk);
      #1;
    end
    rst     = 1'b0;
    rq_req  = 2'b00;
    mem_ack = 1'b0;
    model_reset();
  endtask

  task automatic drive_req(input int i, input logic we, input logic [XLEN-1:0] adr,
                           input logic [XLEN-1:0] d, input biu_size_t sz);
    rq_req[i]  = 1'b1;
    rq_we[i]   = we;
    rq_adr[i]  = adr;
    rq_d[i]    = d;
    rq_size[i] = sz;
  endtask

  task automatic drop_granted();
    rq_req = rq_req & ~obs_gnt;
  endtask

  initial begin
    int lsu_cnt;
    bit aux_seen;
    int rate;
    model_reset();
    do_reset();

    // Single LSU load with a 3-cycle memory latency
    drive_req(0, 1'b0, 32'h100, '0, BIU_WORD);
    run_cycle(); check_eq("t020_gnt", obs_gnt, 2'b01); drop_granted();
    run_cycle();
    check_eq("t020_madr", mem_adr, 32'h100);
    run_cycle();
    mem_ack = 1'b1; mem_q = 32'hDEADBEEF;
    run_cycle();
    check_eq("t020_ack", obs_ack, 2'b01);
    check_eq("t020_q", obs_q, 32'hDEADBEEF);
    mem_ack = 1'b0;
    run_cycle();

    // Simultaneous requests from IDLE, then a tie that exposes the arbitration policy
    do_reset();
    drive_req(0, 1'b1, 32'h140, 32'h11, BIU_WORD);
    drive_req(1, 1'b0, 32'h180, '0, BIU_WORD);
    run_cycle(); check_eq("t021_first", obs_gnt, 2'b01); drop_granted();
    run_cycle(); check_eq("t021_wait", obs_gnt, 2'b00);
    mem_ack = 1'b1; mem_q = $urandom;
    run_cycle(); check_eq("t021_switch", obs_gnt, 2'b10); drop_granted();
    run_cycle();
    mem_ack = 1'b0;
    run_cycle();
    drive_req(0, 1'b0, 32'h1C0, '0, BIU_BYTE);
    run_cycle(); drop_granted();
    mem_ack = 1'b1;
    run_cycle();
    mem_ack = 1'b0;
    run_cycle();
    drive_req(0, 1'b0, 32'h1C4, '0, BIU_HWORD);
    drive_req(1, 1'b0, 32'h1C8, '0, BIU_HWORD);
    run_cycle();
`ifdef RISCV_DMEM_ARB_RR_EN
    check_eq("t021_tie", obs_gnt, 2'b10);
`else
    check_eq("t021_tie", obs_gnt, 2'b01);
`endif

    // Outstanding limit blocks a third LSU issue until the first ack
    do_reset();
    drive_req(0, 1'b0, 32'h200, '0, BIU_WORD);
    run_cycle(); check_eq("t022_g1", obs_gnt, 2'b01);
    rq_adr[0] = 32'h204;
    run_cycle(); check_eq("t022_g2", obs_gnt, 2'b01);
    rq_adr[0] = 32'h208;
    run_cycle(); check_eq("t022_block", obs_gnt, 2'b00);
    run_cycle(); check_eq("t022_block2", obs_gnt, 2'b00);
    mem_ack = 1'b1;
    run_cycle(); check_eq("t022_resume", obs_gnt, 2'b01);
    mem_ack = 1'b0;

    // LSU streaming while AUX waits: burst limit hands over after MB grants
    do_reset();
    drive_req(0, 1'b1, 32'h400, 32'h5, BIU_WORD);
    drive_req(1, 1'b0, 32'h500, '0, BIU_WORD);
    lsu_cnt  = 0;
    aux_seen = 1'b0;
    for (int c = 0; c < 40 && !aux_seen; c++) begin
      mem_ack = (inflight.size() > 0);
      mem_q   = $urandom;
      run_cycle();
      if (obs_gnt[0]) begin lsu_cnt++; rq_adr[0] = rq_adr[0] + 32'd4; end
      if (obs_gnt[1]) aux_seen = 1'b1;
    end
    check_eq("t023_aux_seen", aux_seen, 1'b1);
    check_eq("t023_burst", lsu_cnt, MB);
    mem_ack = 1'b0;

    // Final LSU ack coincides with AUX grant
    do_reset();
    drive_req(0, 1'b0, 32'h280, '0, BIU_WORD);
    run_cycle(); drop_granted();
    drive_req(1, 1'b1, 32'h300, 32'hCAFE, BIU_HWORD);
    run_cycle();
    mem_ack = 1'b1; mem_q = $urandom;
    run_cycle();
    check_eq("t024_ack", obs_ack, 2'b01);
    check_eq("t024_gnt", obs_gnt, 2'b10);
    mem_ack = 1'b0; drop_granted();
    check_eq("t024_mreq", mem_req, 1'b1);
    check_eq("t024_madr", mem_adr, 32'h300);
    run_cycle();

    // Reset with two requests in flight, then confirm the counter restarted from zero
    do_reset();
    drive_req(0, 1'b0, 32'h600, '0, BIU_WORD);
    run_cycle(); rq_adr[0] = 32'h604;
    run_cycle(); drop_granted();
    do_reset();
    drive_req(0, 1'b0, 32'h700, '0, BIU_WORD);
    run_cycle(); check_eq("t025_g1", obs_gnt, 2'b01); rq_adr[0] = 32'h704;
    run_cycle(); check_eq("t025_g2", obs_gnt, 2'b01);
    run_cycle(); check_eq("t025_block", obs_gnt, 2'b00);
    drop_granted();

    // Random traffic against the model
    do_reset();
    rate = 40;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rate = (c % 1000 == 0) ? 90 : 35;
      if (c % 700 == 699) do_reset();
      for (int i = 0; i < 2; i++) begin
        if (!rq_req[i] && $urandom_range(0, 99) < rate)
          drive_req(i, 1'($urandom), $urandom, $urandom, 3'($urandom_range(0, 3)));
      end
      mem_ack        = (inflight.size() > 0) && ($urandom_range(0, 99) < 45);
      mem_q          = $urandom;
      mem_misaligned = 1'($urandom);
      mem_page_fault = 1'($urandom);
      run_cycle();
      drop_granted();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_arb.md
RISCV_DMEM_ARB -- requirements
Module: riscv_dmem_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, max unacknowledged memory requests (1..7).
REQ-003 SHALL have parameter MAX_BURST, default 4, max consecutive issues to one owner while the other waits.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rq_req  in  2  per-requester request; index 0 = LSU, 1 = auxiliary (PTW/debug); held until granted
- rq_we  in  2  per-requester write enable
- rq_adr  in  2 x XLEN  per-requester address
- rq_d  in  2 x XLEN  per-requester write data
- rq_size  in  2 x biu_size_t  per-requester access size
- rq_gnt  out  2  one-hot accept strobe, combinational
- rq_ack  out  2  one-hot completion strobe
- rq_q  out  XLEN  read data, shared, valid with rq_ack
- rq_misaligned  out  1  error, valid with rq_ack
- rq_page_fault  out  1  error, valid with rq_ack
- mem_req  out  1  registered request pulse to memory
- mem_we  out  1  write enable to memory
- mem_adr  out  XLEN  address to memory
- mem_d  out  XLEN  write data to memory
- mem_size  out  biu_size_t  access size to memory
- mem_ack  in  1  in-order completion from memory
- mem_q  in  XLEN  read data from memory
- mem_misaligned  in  1  memory error
- mem_page_fault  in  1  memory error

Function
REQ-005 SHALL implement FSM states IDLE (no owner), OWN0, OWN1; state = current owner.
REQ-006 SHALL keep outstanding counter cnt, 0..MAX_OUTSTANDING; +1 on issue, -1 on mem_ack, unchanged on both.
REQ-007 SHALL assert rq_gnt[i] only if rq_req[i], i is owner or selected new owner, cnt<MAX_OUTSTANDING or mem_ack same cycle, and burst limit not reached.
REQ-008 SHALL register the granted command onto mem_* one cycle after rq_gnt; mem_req a single-cycle pulse per grant.
REQ-009 SHALL change owner only when cnt==0, or cnt==1 with mem_ack in that cycle; may grant the new owner that same cycle.
REQ-010 SHALL route mem_ack/mem_q/mem_misaligned/mem_page_fault combinationally to rq_ack[owner] using the registered owner, so a final ack in a switch cycle goes to the old owner.
REQ-011 SHALL count consecutive grants to the owner (burst); reset on owner change; at MAX_BURST with other rq_req high, stop granting, drain, then switch.
REQ-012 SHALL leave rq_q/error outputs don't-care when no rq_ack; rq_ack never two-hot.
REQ-013 SHALL, with no requests and cnt==0, return to IDLE on the next clock.
REQ-014 SHALL ignore mem_ack when cnt==0 (counter saturates at 0; flagged by assertion).

Reset
REQ-015 SHALL on rst: state IDLE, cnt 0, burst 0, mem_req 0, last_served 1, rq_gnt 0, rq_ack 0; mem_adr/mem_d/mem_we/mem_size don't-care.
REQ-016 SHALL drop in-flight requests on rst; acks arriving after rst are ignored per REQ-014.

Configuration
REQ-017 SHALL, with RISCV_DMEM_ARB_RR_EN defined, pick the new owner in IDLE/switch round-robin against last_served; without it, requester 0 (LSU) always wins simultaneous requests (REQ-011 still prevents starvation).

Structure
REQ-018 SHALL put arb_state_t and requester-index constants (REQ_LSU=0, REQ_AUX=1) in shared package riscv_dmem_arb_pkg; biu_size_t comes from biu_constants_pkg.
REQ-019 SHALL be a single module; no sub-module required.

Verification
REQ-020 Single LSU load, rq_adr[0]=0x100, mem_ack 3 cycles later -> rq_gnt[0] cycle N, mem_req/mem_adr=0x100 N+1, rq_ack[0] with mem_q=0xDEADBEEF.
REQ-021 Both request in IDLE, RR macro off -> LSU granted first; RR on after reset -> LSU first, then AUX next switch.
REQ-022 LSU issues 2 back-to-back, MAX_OUTSTANDING=2, no acks -> third LSU request not granted until first mem_ack.
REQ-023 AUX waiting while LSU streams continuously -> exactly 4 LSU grants, drain to cnt 0, then rq_gnt[1].
REQ-024 Final LSU ack in same cycle AUX is granted -> rq_ack[0] (not [1]) that cycle, mem_req for AUX next cycle.
REQ-025 rst asserted with cnt=2, mem_ack later -> cnt stays 0, no rq_ack, mem_req 0 during and after reset.
